// File: rtl/rr_sel_pkg.sv
// Shared constants and types for the round-robin select sequencer and the downstream 3:1 mux.
package rr_sel_pkg;

  localparam int unsigned DEF_DATA_W = 3;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_C    = 2'b10;
  localparam logic [1:0] SEL_IDLE = 2'b11;

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

endpackage

// File: rtl/rr_slot.sv
// One-entry source buffer: accepts a word when empty, holds it until the arbiter clears it.
module rr_slot #(
  parameter int unsigned DATA_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clear,
  output logic              full,
  output logic [DATA_W-1:0] data
);

  logic              full_q;
  logic [DATA_W-1:0] data_q;

  // Ready depends on stored state only, so no path from downstream ready reaches the source.
  assign in_ready = ~full_q;
  assign full     = full_q;
  assign data     = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (in_valid && !full_q) begin
      full_q <= 1'b1;
      data_q <= in_data;
    end else if (clear) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/rr_sel_sequencer.sv
// Buffers three source channels and grants them round-robin into a registered sel/data output
// with a valid/ready handshake; drives sel=11 and data=0 when idle.
module rr_sel_sequencer
  import rr_sel_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] c_data,
  input  logic              c_valid,
  output logic              c_ready,
  output logic [1:0]        out_sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [DATA_W-1:0] src_data  [3];
  logic [DATA_W-1:0] slot_data [3];
  logic [2:0]        src_valid;
  logic [2:0]        src_ready;
  logic [2:0]        full;
  logic [2:0]        clear;

  assign src_data[0] = a_data;
  assign src_data[1] = b_data;
  assign src_data[2] = c_data;
  assign src_valid   = {c_valid, b_valid, a_valid};
  assign a_ready     = src_ready[0];
  assign b_ready     = src_ready[1];
  assign c_ready     = src_ready[2];

  for (genvar i = 0; i < 3; i++) begin : g_slot
    rr_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .in_data  (src_data[i]),
      .in_valid (src_valid[i]),
      .in_ready (src_ready[i]),
      .clear    (clear[i]),
      .full     (full[i]),
      .data     (slot_data[i])
    );
  end

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        winner;
  logic              found;

  // Search starts one past the last grant so every full slot is reached within three grants.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = SEL_IDLE;
    for (int k = 1; k <= 3; k++) begin
      idx = (int'(last_q) + k) % 3;
      if (!found && full[idx]) begin
        found  = 1'b1;
        winner = 2'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    last_d  = last_q;
    clear   = '0;
    if (state_q == IDLE || out_ready) begin
      if (found) begin
        state_d       = HOLD;
        sel_d         = winner;
        data_d        = slot_data[winner];
        last_d        = winner;
        clear[winner] = 1'b1;
      end else begin
        state_d = IDLE;
        sel_d   = SEL_IDLE;
        data_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= SEL_IDLE;
      data_q  <= '0;
      last_q  <= SEL_C;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_sel   = sel_q;
  assign out_data  = data_q;

endmodule
